// File: rtl/danger_slot_mgr.sv
// danger_slot_mgr: spawns, scrolls and recycles dino-game obstacles across N scroll slots
module danger_slot_mgr #(
   parameter int N_SLOTS    = 3,
   parameter int POS_W      = 9,
   parameter int SPAWN_POS  = 319,
   parameter int GAP_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       pause,
   input  logic                       clear,
   input  logic [2:0]                 speed,
   input  logic [6:0]                 rand_val,
   output logic [N_SLOTS-1:0]         danger_en,
   output logic [N_SLOTS*POS_W-1:0]   danger_pos,
   output logic [N_SLOTS*3-1:0]       danger_type,
   output logic                       spawn_pulse,
   output logic                       full
);
   localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [2:0]      NOTHING  = 3'd5;
   localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

   logic [POS_W-1:0] pos_q [N_SLOTS];
   logic [POS_W-1:0] pos_d [N_SLOTS];
   logic [2:0]       typ_q [N_SLOTS];
   logic [2:0]       typ_d [N_SLOTS];
   logic [N_SLOTS-1:0] en_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [2:0]       pend_q, pend_d;
   logic             eff, spawn, placed;

   function automatic logic [2:0] map_type(input logic [6:0] r);
      return (r <= 7'd50) ? 3'd5 : (r <= 7'd60) ? 3'd4 : (r <= 7'd70) ? 3'd2 :
             (r <= 7'd80) ? 3'd3 : (r <= 7'd90) ? 3'd0 : 3'd1;
   endfunction

   assign eff  = tick & ~pause & ~clear;
   assign full = &danger_en;

   // next state: move live slots, advance gap counter, spawn into the lowest slot free at tick start
   always_comb begin
      en_d   = danger_en;
      pos_d  = pos_q;
      typ_d  = typ_q;
      gap_d  = gap_q;
      pend_d = pend_q;
      spawn  = 1'b0;
      placed = 1'b0;
      if (eff) begin
         for (int i = 0; i < N_SLOTS; i++)
            if (danger_en[i]) begin
               if (pos_q[i] < POS_W'(speed)) begin
                  en_d[i]  = 1'b0;
                  pos_d[i] = '0;
                  typ_d[i] = NOTHING;
               end else
                  pos_d[i] = pos_q[i] - POS_W'(speed);
            end
         if (full)
            gap_d = '0;
         else if (gap_q != GAP_LAST)
            gap_d = gap_q + 1'b1;
         else begin
            pend_d = map_type(rand_val);
            if (pend_q != NOTHING) begin
               spawn = 1'b1;
               gap_d = '0;
               for (int i = 0; i < N_SLOTS; i++)
                  if (!danger_en[i] && !placed) begin
                     placed   = 1'b1;
                     en_d[i]  = 1'b1;
                     pos_d[i] = POS_W'(SPAWN_POS);
                     typ_d[i] = pend_q;
                  end
            end
         end
      end
   end

   // state register; reset and clear both flush every slot and restart the counters
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         danger_en   <= '0;
         gap_q       <= '0;
         pend_q      <= NOTHING;
         spawn_pulse <= 1'b0;
         for (int i = 0; i < N_SLOTS; i++) begin
            pos_q[i] <= '0;
            typ_q[i] <= NOTHING;
         end
      end else begin
         danger_en   <= en_d;
         gap_q       <= gap_d;
         pend_q      <= pend_d;
         spawn_pulse <= spawn;
         pos_q       <= pos_d;
         typ_q       <= typ_d;
      end
   end

   genvar g;
   for (g = 0; g < N_SLOTS; g++) begin : g_out
      assign danger_pos[g*POS_W +: POS_W] = pos_q[g];
      assign danger_type[g*3 +: 3]        = typ_q[g];
   end
endmodule

// File: tb/tb_danger_slot_mgr.sv
// tb_danger_slot_mgr: randomized scoreboard bench for danger_slot_mgr against a behavioural model
module tb_danger_slot_mgr;
   localparam int N   = 3;
   localparam int PW  = 9;
   localparam int GAP = 64;
   localparam int SP  = 319;

   logic clk = 1'b0;
   logic rst, tick, pause, clear;
   logic [2:0] speed;
   logic [6:0] rand_val;
   logic [N-1:0] danger_en;
   logic [N*PW-1:0] danger_pos;
   logic [N*3-1:0] danger_type;
   logic spawn_pulse, full;

   danger_slot_mgr #(.N_SLOTS(N), .POS_W(PW), .SPAWN_POS(SP), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .tick(tick), .pause(pause), .clear(clear), .speed(speed),
      .rand_val(rand_val), .danger_en(danger_en), .danger_pos(danger_pos),
      .danger_type(danger_type), .spawn_pulse(spawn_pulse), .full(full));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0]    en;
      logic [N*PW-1:0] pos;
      logic [N*3-1:0]  typ;
      logic            sp;
      logic            full;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int spawns = 0;

   // behavioural model: obstacle list as plain integers
   bit m_en[N];
   int m_pos[N];
   int m_typ[N];
   int m_gap, m_pend;
   bit m_sp;

   function automatic int map_rand(input int r);
      int tbl[5] = '{4, 2, 3, 0, 1};
      int idx;
      if (r <= 50) return 5;
      idx = (r - 51) / 10;
      return tbl[idx > 4 ? 4 : idx];
   endfunction

   task automatic model_step();
      int free_idx = -1;
      int live = 0;
      m_sp = 0;
      if (!rst || clear) begin
         for (int i = 0; i < N; i++) begin m_en[i] = 0; m_pos[i] = 0; m_typ[i] = 5; end
         m_gap = 0; m_pend = 5;
         return;
      end
      if (!tick || pause) return;
      for (int i = 0; i < N; i++) begin
         live += m_en[i];
         if (!m_en[i] && free_idx < 0) free_idx = i;
      end
      for (int i = 0; i < N; i++)
         if (m_en[i]) begin
            if (m_pos[i] < int'(speed)) begin m_en[i] = 0; m_pos[i] = 0; m_typ[i] = 5; end
            else m_pos[i] -= int'(speed);
         end
      if (live == N) m_gap = 0;
      else if (m_gap < GAP - 1) m_gap++;
      else begin
         if (m_pend != 5) begin
            m_en[free_idx] = 1; m_pos[free_idx] = SP; m_typ[free_idx] = m_pend;
            m_gap = 0; m_sp = 1;
         end
         m_pend = map_rand(int'(rand_val));
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      bit all = 1;
      for (int i = 0; i < N; i++) begin
         e.en[i] = m_en[i];
         e.pos[i*PW +: PW] = m_pos[i][PW-1:0];
         e.typ[i*3 +: 3] = m_typ[i][2:0];
         all &= m_en[i];
      end
      e.sp = m_sp;
      e.full = all;
      return e;
   endfunction

   // one clock: drive inputs away from the edge, update the model, queue the post-edge expectation
   task automatic cyc(input bit rn, input bit t, input bit p, input bit c, input int s, input int r);
      @(negedge clk);
      rst = rn; tick = t; pause = p; clear = c; speed = s[2:0]; rand_val = r[6:0];
      model_step();
      @(posedge clk);
      #1 exp_q.push_back(snapshot());
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // monitor: each cycle the DUT presents its registered outputs, pop and compare
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("danger_en", 64'(danger_en), 64'(e.en));
         chk("danger_pos", 64'(danger_pos), 64'(e.pos));
         chk("danger_type", 64'(danger_type), 64'(e.typ));
         chk("spawn_pulse", 64'(spawn_pulse), 64'(e.sp));
         chk("full", 64'(full), 64'(e.full));
         if (spawn_pulse) spawns++;
      end
   end

   initial begin
      int sp_before;
      rst = 0; tick = 0; pause = 0; clear = 0; speed = 1; rand_val = 55;
      for (int i = 0; i < N; i++) begin m_en[i] = 0; m_pos[i] = 0; m_typ[i] = 5; end
      m_gap = 0; m_pend = 5; m_sp = 0;
      repeat (3) cyc(0, 0, 0, 0, 1, 55);
      // rand 55, speed 1, tick every 4 clks: big cactus spawns at tick 65, freed at 385
      for (int k = 0; k < 390; k++) begin
         cyc(1, 1, 0, 0, 1, 55);
         repeat (3) cyc(1, 0, 0, 0, 1, 55);
      end
      // rand 95: three high birds, full, recycling
      cyc(0, 0, 0, 0, 1, 95);
      for (int k = 0; k < 460; k++) cyc(1, 1, 0, 0, 1, 95);
      // long pause mid-flight with tick still pulsing
      for (int k = 0; k < 100; k++) cyc(1, 1, 1, 0, 1, 95);
      for (int k = 0; k < 40; k++) cyc(1, 1, 0, 0, 2, 95);
      // speed 5 until positions cross zero
      for (int k = 0; k < 80; k++) cyc(1, 1, 0, 0, 5, 95);
      // clear with slots live, then restart count to 65
      cyc(1, 0, 0, 1, 1, 95);
      for (int k = 0; k < 70; k++) cyc(1, 1, 0, 0, 1, 95);
      cyc(0, 1, 0, 0, 1, 95);
      for (int k = 0; k < 70; k++) cyc(1, 1, 0, 0, 1, 95);
      // rand 20: nothing ever spawns
      cyc(0, 0, 0, 0, 1, 20);
      sp_before = spawns;
      for (int k = 0; k < 1000; k++) cyc(1, 1, 0, 0, 1, 20);
      // random mix of all controls
      for (int k = 0; k < 4000; k++)
         cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 127)));
      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      if (spawns == 0) begin
         errors++;
         $display("FAIL spawn_seen: got %0d spawn pulses expected more than 0", spawns);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/danger_slot_mgr.md
# danger_slot_mgr

Parametrised obstacle-slot manager for the dino game: spawns cactus/bird obstacles into N scroll slots from a random source, moves them left at a selectable speed per game tick, and recycles them at the screen edge. It sits between the random generator and the VGA object renderer. It generalises the fixed 3-slot, 1-pixel-per-step obstacle logic with these additions:

- configurable slot count, position width and spawn gap;
- variable speed;
- pause and clear controls;
- single-clock operation with a tick enable.

## Interface
- N_SLOTS, 3, number of obstacle slots (1..8)
- POS_W, 9, horizontal position width
- SPAWN_POS, 319, x position given to a newly spawned obstacle
- GAP_CYCLES, 64, minimum ticks between spawns (≥2)
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset)
- tick  input  1  game-step enable, one clk wide; all movement/spawn happens only on clk edges where tick=1
- pause  input  1  when 1, ticks are ignored (state frozen)
- clear  input  1  synchronous flush of all slots; counters restart
- speed  input  3  pixels moved per tick (0 = frozen scroll, spawn logic still runs)
- rand_val  input  7  random value, sampled on spawn-decision ticks
- danger_en  output  N_SLOTS  slot i occupied
- danger_pos  output  N_SLOTS*POS_W  slot i position at bits [i*POS_W +: POS_W]
- danger_type  output  N_SLOTS*3  slot i type at bits [i*3 +: 3]
- spawn_pulse  output  1  one-clk pulse in the cycle after a spawn
- full  output  1  all slots occupied (combinational AND of danger_en)

## Operation
- Type codes:
  - LOW_BIRD=0, HIGH_BIRD=1, SMALL_CACTUS=2, MANY_CACTUS=3, BIG_CACTUS=4, NOTHING=5.
- rand_val to type mapping:
  - ≤50 → NOTHING
  - ≤60 → BIG_CACTUS
  - ≤70 → SMALL_CACTUS
  - ≤80 → MANY_CACTUS
  - ≤90 → LOW_BIRD
  - else → HIGH_BIRD
- Internal state:
  - gap_cnt: log2(GAP_CYCLES) bits.
  - pending_type: 3 bits, reset to NOTHING.
- Effective tick = tick & ~pause & ~clear. On each effective tick, evaluated in this order from start-of-tick values:
  - Move: each enabled slot:
    - If pos < speed: freed (en=0, pos=0, type=NOTHING).
    - Else: pos -= speed.
    - A slot at pos 0 with speed≥1 is freed. With speed 0 it never moves and is never freed.
  - Gap counter:
    - If full: gap_cnt←0.
    - Else if gap_cnt≠GAP_CYCLES-1: gap_cnt+1.
    - Else (terminal): spawn decision.
  - Spawn decision:
    - If pending_type≠NOTHING: write pos=SPAWN_POS, type=pending_type, en=1 into the lowest-index slot that was free at start of tick; gap_cnt←0; spawn_pulse.
    - Either way: pending_type←map(rand_val).
    - If no spawn occurred, gap_cnt stays at terminal, so the decision repeats every tick.
  - Collision of rules: a spawned slot is not moved in its spawn tick. A slot freed by Move in this tick is not reusable until the next tick.
- clear=1: all slots freed, gap_cnt←0, pending_type←NOTHING, regardless of tick/pause.
- Positions never wrap. Subtraction is guarded by the pos<speed check.

## Timing
- All outputs except full are registered and update on the clk edge where the effective tick is sampled. Results are visible the following cycle.
- spawn_pulse is high exactly one clk after the spawning edge, otherwise 0.
- Reset (rst=0 at an edge): danger_en=0, every pos=0, every type=NOTHING, gap_cnt=0, pending_type=NOTHING, spawn_pulse=0.
- Reset priority: rst > clear > pause > tick. A reset mid-flight discards all obstacles in one cycle.
- First spawn possible on effective tick GAP_CYCLES+1 after reset. The first terminal tick only samples pending_type.
- tick held high for several clks counts as several ticks. The upstream block must pulse it.

## Test plan
- Reset, rand_val=55 constant, speed=1, tick every 4 clks: gap_cnt reaches 63 after 63 ticks. Tick 64 spawns nothing. Tick 65 spawns slot0: pos=319, type=4, spawn_pulse once. Slot0 reads 0 after tick 384 and is freed at tick 385.
- rand_val=20 constant: no spawn ever; danger_en stays 0 for 1000 ticks.
- rand_val=95, speed=1, GAP_CYCLES=64: slots 0,1,2 filled with type 1 at ticks 65,129,193. full=1 while all three live. gap_cnt holds 0 while full. Slot0 is freed at tick 385. The next spawn goes into slot0 at gap terminal +1.
- speed=5, slot at pos 3: next tick frees it (3<5). At pos 5: goes to 0, then is freed on the following tick.
- pause=1 for 100 ticks mid-flight: positions, gap_cnt and spawn_pulse unchanged. Resume continues exactly.
- clear pulse and rst=0 mid-flight with 3 slots live: next cycle all en=0, types=5, pos=0. With rand_val=95, the next spawn occurs at effective tick 65 after release.
